// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO controller: pointer Gray-code conversion and limits.
package async_fifo_pkg;

    localparam int unsigned SYNC_MAX = 4;
    // Widest pointer supported (AW up to 16, plus the wrap bit).
    localparam int unsigned PTR_MAX  = 17;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
module fifo_gray_sync
    import async_fifo_pkg::*;
#(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam int unsigned Depth = (STAGES > SYNC_MAX) ? SYNC_MAX :
                                    (STAGES < 2)        ? 2        : STAGES;

    (* preserve *) logic [W-1:0] stage_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[Depth-1];

endmodule

// File: rtl/async_fifo_ctrl_v2.sv
// Dual-clock FIFO controller driving an external SDP RAM; Gray pointers cross domains,
// with optional first-word-fall-through, programmable level flags and error pulses.
module async_fifo_ctrl_v2
    import async_fifo_pkg::*;
#(
    parameter int unsigned AW          = 11,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FWFT        = 0
) (
    input  logic          wclk,
    input  logic          wrst,
    input  logic          rclk,
    input  logic          rrst,
    input  logic          w_en,
    output logic [AW-1:0] waddr,
    output logic          mem_wr_en,
    output logic          wfull,
    output logic          almost_full,
    input  logic [AW:0]   af_thresh,
    output logic [AW:0]   wr_level,
    output logic          wr_overflow,
    input  logic          r_en,
    output logic [AW-1:0] raddr,
    output logic          mem_rd_en,
    output logic          rempty,
    output logic          almost_empty,
    input  logic [AW:0]   ae_thresh,
    output logic [AW:0]   rd_level,
    output logic          rd_underflow
);

    localparam int unsigned PW = AW + 1;

    // Write domain
    logic [AW:0] wbin_q, wgray_q, wr_level_q, rsync;
    logic [AW:0] wbnext, wgray_next, rsync_bin, wr_level_d;
    logic        wfull_q, wfull_d, wr_overflow_q, w_acc;

    always_comb begin
        w_acc      = w_en & ~wfull_q;
        wbnext     = wbin_q + {{AW{1'b0}}, w_acc};
        wgray_next = PW'(bin2gray(ptr_t'(wbnext)));
        rsync_bin  = PW'(gray2bin(ptr_t'(rsync)));
        // Full when the next write pointer laps the synced read pointer by exactly one depth.
        wfull_d    = (wgray_next == {~rsync[AW:AW-1], rsync[AW-2:0]});
        wr_level_d = wbnext - rsync_bin;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q        <= '0;
            wgray_q       <= '0;
            wfull_q       <= 1'b0;
            wr_level_q    <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            wbin_q        <= wbnext;
            wgray_q       <= wgray_next;
            wfull_q       <= wfull_d;
            wr_level_q    <= wr_level_d;
            wr_overflow_q <= w_en & wfull_q;
        end
    end

    assign waddr       = wbin_q[AW-1:0];
    assign mem_wr_en   = w_acc;
    assign wfull       = wfull_q;
    assign wr_level    = wr_level_q;
    assign almost_full = (wr_level_q >= af_thresh);
    assign wr_overflow = wr_overflow_q;

    // Read domain
    logic [AW:0] rbin_q, rgray_q, rd_level_q, wsync;
    logic [AW:0] rbnext, rgray_next, wsync_bin, rd_level_d;
    logic        rempty_int_q, rempty_int_d, rd_valid_q, rd_valid_d;
    logic        rd_underflow_q, fetch, r_move, rempty_cur;

    always_comb begin
        fetch = ~rempty_int_q & (~rd_valid_q | r_en);
        if (FWFT != 0) begin
            r_move     = fetch;
            rd_valid_d = fetch | (rd_valid_q & ~r_en);
            rempty_cur = ~rd_valid_q;
        end else begin
            r_move     = r_en & ~rempty_int_q;
            rd_valid_d = 1'b0;
            rempty_cur = rempty_int_q;
        end
        rbnext       = rbin_q + {{AW{1'b0}}, r_move};
        rgray_next   = PW'(bin2gray(ptr_t'(rbnext)));
        wsync_bin    = PW'(gray2bin(ptr_t'(wsync)));
        rempty_int_d = (rgray_next == wsync);
        // The word parked in the output register still counts as stored.
        rd_level_d   = wsync_bin - rbnext + {{AW{1'b0}}, rd_valid_d};
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q         <= '0;
            rgray_q        <= '0;
            rempty_int_q   <= 1'b1;
            rd_valid_q     <= 1'b0;
            rd_level_q     <= '0;
            rd_underflow_q <= 1'b0;
        end else begin
            rbin_q         <= rbnext;
            rgray_q        <= rgray_next;
            rempty_int_q   <= rempty_int_d;
            rd_valid_q     <= rd_valid_d;
            rd_level_q     <= rd_level_d;
            rd_underflow_q <= r_en & rempty_cur;
        end
    end

    assign raddr        = rbin_q[AW-1:0];
    assign mem_rd_en    = r_move;
    assign rempty       = rempty_cur;
    assign rd_level     = rd_level_q;
    assign almost_empty = (rd_level_q <= ae_thresh);
    assign rd_underflow = rd_underflow_q;

    fifo_gray_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk (wclk),
        .rst (wrst),
        .d   (rgray_q),
        .q   (rsync)
    );

    fifo_gray_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk (rclk),
        .rst (rrst),
        .d   (wgray_q),
        .q   (wsync)
    );

endmodule

// File: tb/tb_async_fifo_ctrl_v2.sv
// Directed bench: standard-mode instance for fill/drain/threshold/reset, FWFT instance for
// fall-through latency and concurrent scoreboarded traffic across unrelated clocks.
`timescale 1ns/100ps
module tb_async_fifo_ctrl_v2;

    localparam int unsigned AW = 4;
    localparam int N_RAND = 400;

    logic wclk = 1'b0, rclk = 1'b0, wrst = 1'b1, rrst = 1'b1;
    always #5 wclk = ~wclk;
    always #6.5 rclk = ~rclk;

    logic [AW:0] af_thresh = 5'd12, ae_thresh = 5'd3;

    logic          w_en_a = 1'b0, r_en_a = 1'b0, w_en_b = 1'b0, r_en_b = 1'b0;
    logic [AW-1:0] waddr_a, raddr_a, waddr_b, raddr_b;
    logic          mem_wr_en_a, wfull_a, almost_full_a, wr_overflow_a;
    logic          mem_rd_en_a, rempty_a, almost_empty_a, rd_underflow_a;
    logic          mem_wr_en_b, wfull_b, almost_full_b, wr_overflow_b;
    logic          mem_rd_en_b, rempty_b, almost_empty_b, rd_underflow_b;
    logic [AW:0]   wr_level_a, rd_level_a, wr_level_b, rd_level_b;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] wdata_a = 8'h0, wdata_b = 8'h0, rdata_a, rdata_b;
    logic [7:0] sb_q [$];

    int n_total = 0, n_bad = 0, ovf_b = 0, unf_b = 0;

    async_fifo_ctrl_v2 #(.AW(AW), .SYNC_STAGES(2), .FWFT(0)) u_dut_a (
        .wclk(wclk), .wrst(wrst), .rclk(rclk), .rrst(rrst),
        .w_en(w_en_a), .waddr(waddr_a), .mem_wr_en(mem_wr_en_a), .wfull(wfull_a),
        .almost_full(almost_full_a), .af_thresh(af_thresh), .wr_level(wr_level_a),
        .wr_overflow(wr_overflow_a), .r_en(r_en_a), .raddr(raddr_a), .mem_rd_en(mem_rd_en_a),
        .rempty(rempty_a), .almost_empty(almost_empty_a), .ae_thresh(ae_thresh),
        .rd_level(rd_level_a), .rd_underflow(rd_underflow_a)
    );

    async_fifo_ctrl_v2 #(.AW(AW), .SYNC_STAGES(3), .FWFT(1)) u_dut_b (
        .wclk(wclk), .wrst(wrst), .rclk(rclk), .rrst(rrst),
        .w_en(w_en_b), .waddr(waddr_b), .mem_wr_en(mem_wr_en_b), .wfull(wfull_b),
        .almost_full(almost_full_b), .af_thresh(af_thresh), .wr_level(wr_level_b),
        .wr_overflow(wr_overflow_b), .r_en(r_en_b), .raddr(raddr_b), .mem_rd_en(mem_rd_en_b),
        .rempty(rempty_b), .almost_empty(almost_empty_b), .ae_thresh(ae_thresh),
        .rd_level(rd_level_b), .rd_underflow(rd_underflow_b)
    );

    // External SDP RAMs with a registered read port that holds when not enabled.
    always @(posedge wclk) if (mem_wr_en_a) mem_a[waddr_a] <= wdata_a;
    always @(posedge wclk) if (mem_wr_en_b) mem_b[waddr_b] <= wdata_b;
    always @(posedge rclk) if (mem_rd_en_a) rdata_a <= mem_a[raddr_a];
    always @(posedge rclk) if (mem_rd_en_b) rdata_b <= mem_b[raddr_b];

    always @(posedge wclk) if (wr_overflow_b) ovf_b <= ovf_b + 1;
    always @(posedge rclk) if (rd_underflow_b) unf_b <= unf_b + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        repeat (6) @(negedge rclk);
        check("rst_waddr", 32'(waddr_a), 0);
        check("rst_wfull", 32'(wfull_a), 0);
        check("rst_wr_level", 32'(wr_level_a), 0);
        check("rst_almost_full", 32'(almost_full_a), 0);
        check("rst_rempty", 32'(rempty_a), 1);
        check("rst_almost_empty", 32'(almost_empty_a), 1);
        check("rst_rd_level", 32'(rd_level_a), 0);
        check("rst_mem_rd_en", 32'(mem_rd_en_a), 0);
        check("rst_rempty_fwft", 32'(rempty_b), 1);
        wrst = 1'b0;
        rrst = 1'b0;

        // Fill standard-mode FIFO to full, watching the almost-full threshold.
        @(negedge wclk);
        for (int i = 0; i < 16; i++) begin
            w_en_a  = 1'b1;
            wdata_a = 8'(i);
            @(negedge wclk);
            if (i == 10) begin
                check("wr_level_11", 32'(wr_level_a), 11);
                check("af_at_11", 32'(almost_full_a), 0);
            end
            if (i == 11) check("af_at_12", 32'(almost_full_a), 1);
        end
        check("full_after_16", 32'(wfull_a), 1);
        check("wr_level_16", 32'(wr_level_a), 16);
        check("wr_blocked", 32'(mem_wr_en_a), 0);
        @(negedge wclk);
        check("overflow_pulse", 32'(wr_overflow_a), 1);
        check("waddr_held", 32'(waddr_a), 0);
        w_en_a = 1'b0;
        @(negedge wclk);
        check("overflow_end", 32'(wr_overflow_a), 0);

        // Drain in order, watching the almost-empty threshold.
        repeat (6) @(negedge rclk);
        check("rd_level_16", 32'(rd_level_a), 16);
        check("not_empty", 32'(rempty_a), 0);
        for (int i = 0; i < 16; i++) begin
            r_en_a = 1'b1;
            @(negedge rclk);
            check("drain_data", 32'(rdata_a), 32'(i));
            if (i == 11) begin
                check("rd_level_4", 32'(rd_level_a), 4);
                check("ae_at_4", 32'(almost_empty_a), 0);
            end
            if (i == 12) check("ae_at_3", 32'(almost_empty_a), 1);
        end
        check("empty_after_16", 32'(rempty_a), 1);
        check("rd_level_0", 32'(rd_level_a), 0);
        check("rd_blocked", 32'(mem_rd_en_a), 0);
        @(negedge rclk);
        check("underflow_pulse", 32'(rd_underflow_a), 1);
        check("raddr_held", 32'(raddr_a), 0);
        r_en_a = 1'b0;
        @(negedge rclk);
        check("underflow_end", 32'(rd_underflow_a), 0);

        // FWFT: single word falls through without r_en.
        @(negedge wclk);
        w_en_b  = 1'b1;
        wdata_b = 8'hA5;
        @(negedge wclk);
        w_en_b = 1'b0;
        check("fwft_empty_before", 32'(rempty_b), 1);
        cnt = 0;
        while (rempty_b && cnt < 12) begin
            @(negedge rclk);
            cnt++;
        end
        check("fwft_latency_ok", 32'(cnt <= 6), 1);
        check("fwft_data", 32'(rdata_b), 32'hA5);
        check("fwft_level_1", 32'(rd_level_b), 1);
        r_en_b = 1'b1;
        @(negedge rclk);
        r_en_b = 1'b0;
        check("fwft_empty_after", 32'(rempty_b), 1);
        check("fwft_level_0", 32'(rd_level_b), 0);
        check("fwft_no_underflow", 32'(rd_underflow_b), 0);

        // Concurrent random traffic on the FWFT instance, checked against a scoreboard.
        fork
            begin
                int sent = 0;
                while (sent < N_RAND) begin
                    @(negedge wclk);
                    if (!wfull_b && $urandom_range(0, 3) != 0) begin
                        w_en_b  = 1'b1;
                        wdata_b = 8'(sent * 7 + 3);
                        sb_q.push_back(wdata_b);
                        sent++;
                    end else begin
                        w_en_b = 1'b0;
                    end
                end
                @(negedge wclk);
                w_en_b = 1'b0;
            end
            begin
                int got = 0;
                int guard = 0;
                logic [7:0] exp;
                while (got < N_RAND && guard < 20000) begin
                    @(negedge rclk);
                    guard++;
                    if (!rempty_b && sb_q.size() != 0 && $urandom_range(0, 2) != 0) begin
                        r_en_b = 1'b1;
                        exp = sb_q.pop_front();
                        check("rand_data", 32'(rdata_b), 32'(exp));
                        got++;
                    end else begin
                        r_en_b = 1'b0;
                    end
                end
                @(negedge rclk);
                r_en_b = 1'b0;
                check("rand_count", 32'(got), 32'(N_RAND));
            end
        join
        repeat (8) @(negedge rclk);
        check("rand_no_overflow", 32'(ovf_b), 0);
        check("rand_no_underflow", 32'(unf_b), 0);
        check("rand_final_empty", 32'(rempty_b), 1);
        check("rand_final_rd_level", 32'(rd_level_b), 0);
        check("rand_final_wr_level", 32'(wr_level_b), 0);

        // Reset mid-operation with 9 words stored.
        @(negedge wclk);
        for (int i = 0; i < 9; i++) begin
            w_en_a  = 1'b1;
            wdata_a = 8'(8'h40 + i);
            @(negedge wclk);
        end
        w_en_a = 1'b0;
        repeat (4) @(negedge rclk);
        check("pre_reset_level", 32'(rd_level_a), 9);
        wrst = 1'b1;
        rrst = 1'b1;
        #1;
        check("mid_rst_waddr", 32'(waddr_a), 0);
        check("mid_rst_wr_level", 32'(wr_level_a), 0);
        check("mid_rst_rempty", 32'(rempty_a), 1);
        check("mid_rst_rd_level", 32'(rd_level_a), 0);
        check("mid_rst_raddr", 32'(raddr_a), 0);
        check("mid_rst_almost_empty", 32'(almost_empty_a), 1);
        repeat (6) @(negedge rclk);
        wrst = 1'b0;
        rrst = 1'b0;
        @(negedge wclk);
        w_en_a  = 1'b1;
        wdata_a = 8'h3C;
        @(negedge wclk);
        w_en_a = 1'b0;
        cnt = 0;
        while (rempty_a && cnt < 20) begin
            @(negedge rclk);
            cnt++;
        end
        check("post_rst_visible", 32'(rempty_a), 0);
        r_en_a = 1'b1;
        @(negedge rclk);
        r_en_a = 1'b0;
        check("post_rst_data", 32'(rdata_a), 32'h3C);
        check("post_rst_empty", 32'(rempty_a), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
